// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity, stop bits and oversample.
// Bit timing comes from an external i_clk_tx enable; every output is registered.
module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_tx,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 TxStart,
  output logic                 o_busy,
  output logic                 TxDone,
  output logic                 o_txd
);

  localparam int unsigned CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic                 stop_idx, stop_nxt;
  logic [DATA_BITS-1:0] data_reg, data_nxt;
  logic                 txd_nxt, busy_nxt, done_nxt;
  logic                 last_tick;
  logic                 par_bit;

  assign last_tick = i_clk_tx && (tick_cnt == CW'(OVERSAMPLE - 1));
  // Parity always comes from the captured word, so mid-frame i_data changes cannot leak in.
  assign par_bit   = (^data_reg) ^ (PARITY == 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data_reg <= '0;
      o_txd    <= 1'b1;
      o_busy   <= 1'b0;
      TxDone   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_idx  <= bit_nxt;
      stop_idx <= stop_nxt;
      data_reg <= data_nxt;
      o_txd    <= txd_nxt;
      o_busy   <= busy_nxt;
      TxDone   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    data_nxt  = data_reg;
    txd_nxt   = o_txd;
    busy_nxt  = o_busy;
    done_nxt  = 1'b0;

    // Tick counter runs only while a frame is in flight; wraps on the last tick of each bit.
    if (state != S_IDLE && i_clk_tx) begin
      tick_nxt = last_tick ? '0 : tick_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        txd_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (TxStart) begin
          data_nxt  = i_data;
          tick_nxt  = '0;
          bit_nxt   = '0;
          stop_nxt  = 1'b0;
          state_nxt = S_START;
          txd_nxt   = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      S_START: begin
        if (last_tick) begin
          state_nxt = S_DATA;
          bit_nxt   = '0;
          txd_nxt   = data_reg[0];
        end
      end
      S_DATA: begin
        if (last_tick) begin
          if (bit_idx == BW'(DATA_BITS - 1)) begin
            stop_nxt = 1'b0;
            if (PARITY != 0) begin
              state_nxt = S_PAR;
              txd_nxt   = par_bit;
            end else begin
              state_nxt = S_STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            bit_nxt = bit_idx + BW'(1);
            txd_nxt = data_reg[bit_nxt];
          end
        end
      end
      S_PAR: begin
        if (last_tick) begin
          state_nxt = S_STOP;
          stop_nxt  = 1'b0;
          txd_nxt   = 1'b1;
        end
      end
      S_STOP: begin
        txd_nxt = 1'b1;
        if (last_tick) begin
          if (stop_idx == 1'(STOP_BITS - 1)) begin
            state_nxt = S_IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        tick_nxt  = '0;
        bit_nxt   = '0;
        stop_nxt  = 1'b0;
        txd_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four configurations, table-driven frames plus hand-written
// sequences for re-trigger, back-to-back, async reset and tick stall.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick0, tick3;
  logic [8:0] din;
  logic [3:0] start;
  logic [3:0] txd, busy, done;

  int checks   = 0;
  int failures = 0;
  logic sb_q[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(rst), .i_clk_tx(tick0), .i_data(din[7:0]), .TxStart(start[0]),
    .o_busy(busy[0]), .TxDone(done[0]), .o_txd(txd[0]));
  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst), .i_clk_tx(tick0), .i_data(din[7:0]), .TxStart(start[1]),
    .o_busy(busy[1]), .TxDone(done[1]), .o_txd(txd[1]));
  uart_tx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(rst), .i_clk_tx(tick0), .i_data(din[7:0]), .TxStart(start[2]),
    .o_busy(busy[2]), .TxDone(done[2]), .o_txd(txd[2]));
  uart_tx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(rst), .i_clk_tx(tick3), .i_data(din[6:0]), .TxStart(start[3]),
    .o_busy(busy[3]), .TxDone(done[3]), .o_txd(txd[3]));

  typedef struct {
    int         k;
    logic [8:0] data;
    int         nd;
    int         par;
    logic       pbit;
    int         nstop;
    int         os;
    int         p;
    int         len;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_tick(input int k, input logic t);
    if (k == 3) tick3 = t;
    else tick0 = t;
  endtask

  // mode 0: plain frame; 1: re-pulse TxStart with new data mid-frame;
  // 2: hold TxStart through TxDone; 3: stall ticks for 1000 clk mid data bit.
  task automatic run_frame(input vec_t v, input int mode);
    int         nb, c, tc, bit_i, stall;
    logic       expb, t;
    logic [2:0] first_act;
    bit         bad;
    nb    = 1 + v.nd + ((v.par != 0) ? 1 : 0) + v.nstop;
    stall = (mode == 3) ? 1000 : 0;
    sb_q.push_back(1'b0);
    for (int i = 0; i < v.nd; i++) sb_q.push_back(v.data[i]);
    if (v.par != 0) sb_q.push_back(v.pbit);
    for (int i = 0; i < v.nstop; i++) sb_q.push_back(1'b1);

    din = v.data;
    start[v.k] = 1'b1;
    set_tick(v.k, 1'b0);
    @(posedge clk); #1;
    if (mode != 2) start[v.k] = 1'b0;

    c = 0; tc = 0; bit_i = 0; bad = 1'b0; first_act = '0;
    expb = sb_q.pop_front();
    while (bit_i < nb && c < 20000) begin
      if (!bad && {busy[v.k], done[v.k], txd[v.k]} !== {2'b10, expb}) begin
        bad = 1'b1;
        first_act = {busy[v.k], done[v.k], txd[v.k]};
      end
      c++;
      t = (c % v.p == 0) && !(mode == 3 && c >= 40 && c < 40 + stall);
      set_tick(v.k, t);
      if (mode == 1 && c == 50) begin start[v.k] = 1'b1; din = 9'h0FF; end
      if (mode == 1 && c == 51) start[v.k] = 1'b0;
      @(posedge clk); #1;
      if (t) tc++;
      if (tc == v.os) begin
        tc = 0;
        check($sformatf("dut%0d bit%0d busy/done/txd", v.k, bit_i),
              bad ? 32'(first_act) : 32'({2'b10, expb}), 32'({2'b10, expb}));
        bit_i++;
        bad = 1'b0;
        if (bit_i < nb) expb = sb_q.pop_front();
      end
    end
    check($sformatf("dut%0d frame timeout", v.k), 32'(bit_i), 32'(nb));
    check($sformatf("dut%0d frame length clk", v.k), 32'(c), 32'(v.len + stall));
    check($sformatf("dut%0d completion busy/done/txd", v.k),
          32'({busy[v.k], done[v.k], txd[v.k]}), 32'(3'b011));
    set_tick(v.k, 1'b0);
    @(posedge clk); #1;
    if (mode == 2)
      check($sformatf("dut%0d back-to-back accept busy/done/txd", v.k),
            32'({busy[v.k], done[v.k], txd[v.k]}), 32'(3'b100));
    else
      check($sformatf("dut%0d post-frame idle busy/done/txd", v.k),
            32'({busy[v.k], done[v.k], txd[v.k]}), 32'(3'b001));
  endtask

  initial begin
    int errs;
    vt[0] = '{k:0, data:9'h0A5, nd:8, par:0, pbit:1'b0, nstop:1, os:16, p:1, len:160};
    vt[1] = '{k:1, data:9'h007, nd:8, par:1, pbit:1'b1, nstop:1, os:16, p:1, len:176};
    vt[2] = '{k:1, data:9'h003, nd:8, par:1, pbit:1'b0, nstop:1, os:16, p:1, len:176};
    vt[3] = '{k:2, data:9'h007, nd:8, par:2, pbit:1'b0, nstop:1, os:16, p:1, len:176};
    vt[4] = '{k:2, data:9'h003, nd:8, par:2, pbit:1'b1, nstop:1, os:16, p:1, len:176};
    vt[5] = '{k:3, data:9'h055, nd:7, par:0, pbit:1'b0, nstop:2, os:8,  p:3, len:240};

    rst = 1'b1; tick0 = 1'b0; tick3 = 1'b0; din = '0; start = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("dut%0d reset busy/done/txd", k),
            32'({busy[k], done[k], txd[k]}), 32'(3'b001));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_frame(vt[i], 0);

    // Mid-frame re-trigger with new data must neither corrupt nor queue a frame.
    run_frame(vt[0], 1);
    errs = 0;
    tick0 = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) errs++;
    end
    check("dut0 no queued frame after re-pulse", 32'(errs), 32'(0));

    run_frame(vt[0], 3);

    // Back-to-back, then async reset in the middle of the follow-on frame.
    run_frame(vt[0], 2);
    start[0] = 1'b0;
    tick0 = 1'b1;
    repeat (69) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("dut0 async reset busy/done/txd", 32'({busy[0], done[0], txd[0]}), 32'(3'b001));
    errs = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done[0] !== 1'b0) errs++;
    end
    rst = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) errs++;
    end
    check("dut0 idle after reset release", 32'(errs), 32'(0));
    check("scoreboard drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
